// File: rtl/salsa20_core_ctrl.sv
// Salsa20 core controller: one single round per clock, then feedforward add.
// Optional abort input enabled by defining SALSA20_CTRL_ABORT_EN.
module salsa20_core_ctrl #(
   parameter int unsigned DOUBLE_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
`ifdef SALSA20_CTRL_ABORT_EN
   input  logic         abort,
`endif
   input  logic [511:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [511:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   typedef logic [15:0][31:0] blk_t;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL,
      DONE
   } state_t;

   localparam logic [4:0] LAST = 5'(2 * DOUBLE_ROUNDS - 1);

   state_t     state;
   state_t     state_nxt;
   blk_t       st;
   blk_t       saved;
   blk_t       sum;
   blk_t       st_col;
   blk_t       st_row;
   logic [4:0] cnt;
   logic       load;
   logic       step;
   logic       fin;
   logic       abort_w;

`ifdef SALSA20_CTRL_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   function automatic logic [31:0] rotl(
      input logic [31:0] v,
      input logic [4:0]  n
   );
      return (v << n) | (v >> (5'd0 - n));
   endfunction

   function automatic blk_t qr(
      input blk_t       x,
      input logic [3:0] a,
      input logic [3:0] b,
      input logic [3:0] c,
      input logic [3:0] d
   );
      blk_t y;
      y    = x;
      y[b] = y[b] ^ rotl(y[a] + y[d], 5'd7);
      y[c] = y[c] ^ rotl(y[b] + y[a], 5'd9);
      y[d] = y[d] ^ rotl(y[c] + y[b], 5'd13);
      y[a] = y[a] ^ rotl(y[d] + y[c], 5'd18);
      return y;
   endfunction

   function automatic blk_t col_round(input blk_t x);
      blk_t y;
      y = qr(x, 4'd0, 4'd4, 4'd8, 4'd12);
      y = qr(y, 4'd5, 4'd9, 4'd13, 4'd1);
      y = qr(y, 4'd10, 4'd14, 4'd2, 4'd6);
      y = qr(y, 4'd15, 4'd3, 4'd7, 4'd11);
      return y;
   endfunction

   function automatic blk_t row_round(input blk_t x);
      blk_t y;
      y = qr(x, 4'd0, 4'd1, 4'd2, 4'd3);
      y = qr(y, 4'd5, 4'd6, 4'd7, 4'd4);
      y = qr(y, 4'd10, 4'd11, 4'd8, 4'd9);
      y = qr(y, 4'd15, 4'd12, 4'd13, 4'd14);
      return y;
   endfunction

   assign st_col = col_round(st);
   assign st_row = row_round(st);

   // Feedforward is a per-word add; carries never cross word lanes.
   for (genvar i = 0; i < 16; i++) begin : g_sum
      assign sum[i] = st[i] + saved[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      fin       = 1'b0;
      if (abort_w) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  load      = 1'b1;
                  state_nxt = ROUND;
               end
            end
            ROUND: begin
               step = 1'b1;
               if (cnt == LAST) begin
                  state_nxt = FINAL;
               end
            end
            FINAL: begin
               fin       = 1'b1;
               state_nxt = DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state_nxt = IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= '0;
         saved     <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (load) begin
            st    <= in_data;
            saved <= in_data;
            cnt   <= '0;
         end else if (step) begin
            st  <= cnt[0] ? st_row : st_col;
            cnt <= cnt + 5'd1;
         end
         if (fin) begin
            out_data <= sum;
         end
         out_valid <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_salsa20_core_ctrl.sv
// Directed bench for salsa20_core_ctrl: Salsa20/20 and Salsa20/8 instances
// checked against a software core model; abort cases when enabled.
module tb_salsa20_core_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] in_data;
   logic         in_valid;
   logic         out_ready;
   logic         sel;
`ifdef SALSA20_CTRL_ABORT_EN
   logic         abort;
`endif

   logic         ir20, ov20, bz20;
   logic         ir8, ov8, bz8;
   logic [511:0] od20, od8;

   logic         in_ready, out_valid, busy;
   logic [511:0] out_data;

   int nerr = 0;
   int nchk = 0;

   always #5 clk = ~clk;

   salsa20_core_ctrl u_dut20 (
      .clk      (clk),
      .rst      (rst),
`ifdef SALSA20_CTRL_ABORT_EN
      .abort    (abort),
`endif
      .in_data  (in_data),
      .in_valid (in_valid & ~sel),
      .in_ready (ir20),
      .out_data (od20),
      .out_valid(ov20),
      .out_ready(out_ready & ~sel),
      .busy     (bz20)
   );

   salsa20_core_ctrl #(.DOUBLE_ROUNDS(4)) u_dut8 (
      .clk      (clk),
      .rst      (rst),
`ifdef SALSA20_CTRL_ABORT_EN
      .abort    (1'b0),
`endif
      .in_data  (in_data),
      .in_valid (in_valid & sel),
      .in_ready (ir8),
      .out_data (od8),
      .out_valid(ov8),
      .out_ready(out_ready & sel),
      .busy     (bz8)
   );

   assign in_ready  = sel ? ir8 : ir20;
   assign out_valid = sel ? ov8 : ov20;
   assign busy      = sel ? bz8 : bz20;
   assign out_data  = sel ? od8 : od20;

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] qr4(input logic [31:0] y0, y1, y2, y3);
      y1 = y1 ^ rl(y0 + y3, 7);
      y2 = y2 ^ rl(y1 + y0, 9);
      y3 = y3 ^ rl(y2 + y1, 13);
      y0 = y0 ^ rl(y3 + y2, 18);
      return {y0, y1, y2, y3};
   endfunction

   function automatic logic [511:0] salsa_ref(input logic [511:0] din,
                                               input int dr);
      int colidx[16] = '{0, 4, 8, 12, 5, 9, 13, 1,
                         10, 14, 2, 6, 15, 3, 7, 11};
      int rowidx[16] = '{0, 1, 2, 3, 5, 6, 7, 4,
                         10, 11, 8, 9, 15, 12, 13, 14};
      logic [31:0]  x[16];
      logic [127:0] t;
      logic [511:0] r;
      int a, b, c, d;
      for (int i = 0; i < 16; i++) x[i] = din[i*32 +: 32];
      for (int k = 0; k < 2 * dr; k++) begin
         for (int q = 0; q < 4; q++) begin
            a = (k % 2 == 0) ? colidx[4*q]   : rowidx[4*q];
            b = (k % 2 == 0) ? colidx[4*q+1] : rowidx[4*q+1];
            c = (k % 2 == 0) ? colidx[4*q+2] : rowidx[4*q+2];
            d = (k % 2 == 0) ? colidx[4*q+3] : rowidx[4*q+3];
            t = qr4(x[a], x[b], x[c], x[d]);
            x[a] = t[127:96];
            x[b] = t[95:64];
            x[c] = t[63:32];
            x[d] = t[31:0];
         end
      end
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = x[i] + din[i*32 +: 32];
      return r;
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   // Accept one block, then wait (bounded) for out_valid.
   task automatic run(input logic [511:0] d, output int lat, output int bcnt);
      in_data  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat  = 0;
      bcnt = 0;
      while (!out_valid && lat < 200) begin
         if (busy) bcnt++;
         step();
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   logic [511:0] v;
   logic [511:0] exp;
   logic [127:0] q;
   int lat, bcnt, seen;

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sel       = 1'b0;
`ifdef SALSA20_CTRL_ABORT_EN
      abort     = 1'b0;
`endif

      q = qr4(32'h1, 32'h0, 32'h0, 32'h0);
      chk("model_qr", q, {32'h08008145, 32'h00000080,
                          32'h00010200, 32'h20500000});

      step();
      step();
      rst = 1'b0;
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_od", out_data, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ir", in_ready, 1'b1);

      run('0, lat, bcnt);
      chk("zero_lat", lat, 21);
      chk("zero_busy", bcnt, 21);
      chk("zero_od", out_data, '0);
      drain();
      chk("zero_ov_clr", out_valid, 1'b0);
      chk("zero_ir", in_ready, 1'b1);

      for (int n = 0; n < 10; n++) begin
         v = rnd512();
         run(v, lat, bcnt);
         chk("rnd_lat", lat, 21);
         chk("rnd_od", out_data, salsa_ref(v, 10));
         drain();
      end

      v   = rnd512();
      exp = salsa_ref(v, 10);
      run(v, lat, bcnt);
      chk("hold_lat", lat, 21);
      for (int k = 0; k < 5; k++) begin
         in_data  = rnd512();
         in_valid = (k % 2 == 0);
         step();
         chk("hold_ov", out_valid, 1'b1);
         chk("hold_od", out_data, exp);
         chk("hold_ir", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      drain();
      chk("hold_ir_back", in_ready, 1'b1);
      chk("hold_busy", busy, 1'b0);
      chk("hold_ov_clr", out_valid, 1'b0);
      step();
      chk("hold_stay_idle", busy, 1'b0);

      in_data  = rnd512();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (6) step();
      chk("mid_busy", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_ov", out_valid, 1'b0);
      chk("mrst_ir", in_ready, 1'b1);
      chk("mrst_busy", busy, 1'b0);
      run('0, lat, bcnt);
      chk("mrst_lat", lat, 21);
      chk("mrst_od", out_data, '0);
      drain();

`ifdef SALSA20_CTRL_ABORT_EN
      in_data  = rnd512();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abt_ir", in_ready, 1'b1);
      chk("abt_busy", busy, 1'b0);
      chk("abt_ov", out_valid, 1'b0);
      seen = 0;
      repeat (25) begin
         step();
         if (out_valid) seen++;
      end
      chk("abt_no_ov", seen, 0);
      abort    = 1'b1;
      in_valid = 1'b1;
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abt_no_acc", busy, 1'b0);
`endif

      sel = 1'b1;
      step();
      chk("r8_ir", in_ready, 1'b1);
      for (int n = 0; n < 2; n++) begin
         v = (n == 0) ? '0 : rnd512();
         run(v, lat, bcnt);
         chk("r8_lat", lat, 9);
         chk("r8_busy", bcnt, 9);
         chk("r8_od", out_data, salsa_ref(v, 4));
         drain();
         chk("r8_ov_clr", out_valid, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/salsa20_core_ctrl.md
SALSA20_CORE_CTRL -- requirements
Module: salsa20_core_ctrl

Interface
REQ-001 The block SHALL have parameter DOUBLE_ROUNDS, default 10, the number of double rounds per block (legal range 1..15; 4 gives Salsa20/8, 10 gives Salsa20/20).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port in_data, input, 512 bits, sixteen 32-bit words, word i at bits [32i+31:32i].
REQ-005 The block SHALL have port in_valid, input, 1 bit, in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block can accept in_data.
REQ-007 The block SHALL have port out_data, output, 512 bits, keystream block, same word packing as in_data.
REQ-008 The block SHALL have port out_valid, output, 1 bit, out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, consumer accepts out_data.
REQ-010 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, ROUND, FINAL, DONE.
REQ-012 The block SHALL drive in_ready high only in IDLE.
REQ-013 In IDLE, on in_valid&&in_ready, the block SHALL load the working state and a saved copy from in_data, clear the 5-bit round counter and go to ROUND.
REQ-014 In ROUND, the block SHALL apply one single round per cycle: column round (odd_round) when counter bit 0 = 0, row round (even_round) when it is 1, then increment the counter.
REQ-015 The block SHALL leave ROUND for FINAL on the cycle the counter equals 2*DOUBLE_ROUNDS-1.
REQ-016 In FINAL, the block SHALL register out_data[i] = state[i] + saved[i] mod 2^32 for each word i (no carry between words), set out_valid and go to DONE.
REQ-017 out_valid SHALL first be high 2*DOUBLE_ROUNDS+1 cycles after the accepting edge (21 for the default).
REQ-018 In DONE, the block SHALL hold out_data and out_valid stable while out_ready is low.
REQ-019 In DONE, on out_ready high, the block SHALL clear out_valid and return to IDLE; in_ready SHALL be high on the following cycle (no overlap of blocks).
REQ-020 While busy, in_valid and in_data SHALL be ignored.
REQ-021 out_ready outside DONE SHALL have no effect.

Reset
REQ-022 On rst high at a clock edge, in any state, the block SHALL enter IDLE with out_valid=0, out_data=0, busy=0, in_ready=1 and the counter at 0.
REQ-023 rst SHALL have priority over every other input; a block in progress SHALL be discarded without output.

Configuration
REQ-024 With macro SALSA20_CTRL_ABORT_EN defined, the block SHALL add input abort (1 bit); abort high at an edge SHALL return the block to IDLE with out_valid=0, keeping out_data unchanged.
REQ-025 abort SHALL have priority over in_valid in the same cycle (no accept) and lower priority than rst.
REQ-026 Without SALSA20_CTRL_ABORT_EN, the abort port SHALL NOT exist and the behaviour SHALL be exactly REQ-011..REQ-023.

Verification
REQ-027 The bench SHALL check the following: reset, then in_data all zero with in_valid pulse -> out_valid after 21 cycles, out_data all zero, busy high for exactly 21 cycles before out_valid.
REQ-028 The bench SHALL check the following: random in_data (10 vectors) against a software Salsa20/20 core model -> bit-exact out_data, word 0 at bits [31:0].
REQ-029 The bench SHALL check the following: out_ready held low 5 cycles after out_valid -> out_data/out_valid stable, in_ready low, in_valid pulses ignored; IDLE one cycle after out_ready.
REQ-030 The bench SHALL check the following: rst asserted on the 7th ROUND cycle -> next cycle out_valid=0, in_ready=1, busy=0; a following all-zero block completes normally in 21 cycles.
REQ-031 The bench SHALL check the following: DOUBLE_ROUNDS=4 -> latency 9 cycles and match to the Salsa20/8 model.
REQ-032 The bench SHALL check the following: with SALSA20_CTRL_ABORT_EN defined, abort in ROUND -> IDLE next cycle, no out_valid; abort together with in_valid in IDLE -> no accept.
